// File: rtl/rx_buff_pkg.sv
// ----------------------------------------------------------------------------
// rx_buff_pkg
// Shared definitions for the HDLC receive frame buffer:
//   - wr_state_t : write-side FSM states
//   - DEF_*      : default parameter values for rx_frame_buff / rx_slot_mem
//   - CNT_W      : word-count width for the default DEPTH ($clog2(DEPTH+1))
//   - PTR_W      : slot-pointer width for the default NUM_SLOTS
// ----------------------------------------------------------------------------
package rx_buff_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 128;
    localparam int DEF_NUM_SLOTS = 2;
    localparam int DEF_FCS_BYTES = 2;

    localparam int CNT_W = $clog2(DEF_DEPTH + 1);
    localparam int PTR_W = $clog2(DEF_NUM_SLOTS);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,   // waiting for the first word of a frame
        WR_FILL = 2'd1,   // storing words into the claimed slot
        WR_SKIP = 2'd2    // no slot was free; swallow the frame until it ends
    } wr_state_t;

endpackage

// File: rtl/rx_slot_mem.sv
// ----------------------------------------------------------------------------
// rx_slot_mem
// One frame slot: DEPTH x DATA_W word storage plus the slot's full flag and
// committed payload size.
// Ports:
//   Clk, Rst             clock, asynchronous active-low reset
//   WrEn/WrIdx/WrData    store one word (visible on the next edge)
//   Commit/CommitSize    mark the slot full with the given payload size
//   RelSlot              mark the slot free again
//   RdIdx/RdData         combinational read of one stored word
//   Full, Size           slot status
// ----------------------------------------------------------------------------
module rx_slot_mem
    import rx_buff_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = rx_buff_pkg::CNT_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WrEn,
    input  logic [IDX_W-1:0]  WrIdx,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Commit,
    input  logic [CNT_W-1:0]  CommitSize,
    input  logic              RelSlot,
    input  logic [IDX_W-1:0]  RdIdx,
    output logic [DATA_W-1:0] RdData,
    output logic              Full,
    output logic [CNT_W-1:0]  Size
);

    // Word storage carries no reset: contents only matter once committed.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem[WrIdx] <= WrData;
        end
    end

    // First-word fall-through: the reader sees the word without a wait state.
    assign RdData = mem[RdIdx];

    // Commit and release never target the same slot in one cycle: a slot is
    // only written while free and only released while full.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Full <= 1'b0;
            Size <= '0;
        end else if (Commit) begin
            Full <= 1'b1;
            Size <= CommitSize;
        end else if (RelSlot) begin
            Full <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_frame_buff.sv
// ----------------------------------------------------------------------------
// rx_frame_buff
// Multi-slot receive frame buffer between the HDLC byte assembler/FCS checker
// and the host RX register interface. Frames are written into a ring of
// NUM_SLOTS slots and handed to the reader in arrival order; aborted, errored,
// runt and overflowed frames are discarded, FCS words are excluded from size.
// Ports:
//   Clk, Rst                  clock, asynchronous active-low reset
//   DataBuff, WrBuff          incoming word and its write strobe
//   EoF, FrameError,
//   AbortedFrame              end / error / abort status of the incoming frame
//   ReadBuff, Drop            consume one word / discard the head frame
//   RxReady, RxDataBuffOut,
//   FrameSize                 head frame status, current word and payload size
//   Overflow                  incoming frame exceeded DEPTH words (sticky)
//   FrameLost                 pulse: incoming frame dropped, no slot free
//   SlotsUsed                 committed slots not yet released
// ----------------------------------------------------------------------------
module rx_frame_buff
    import rx_buff_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int FCS_BYTES = DEF_FCS_BYTES
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [DATA_W-1:0]              DataBuff,
    input  logic                           WrBuff,
    input  logic                           EoF,
    input  logic                           FrameError,
    input  logic                           AbortedFrame,
    input  logic                           ReadBuff,
    input  logic                           Drop,
    output logic                           RxReady,
    output logic [DATA_W-1:0]              RxDataBuffOut,
    output logic [$clog2(DEPTH+1)-1:0]     FrameSize,
    output logic                           Overflow,
    output logic                           FrameLost,
    output logic [$clog2(NUM_SLOTS+1)-1:0] SlotsUsed
);

    localparam int CntW  = $clog2(DEPTH + 1);
    localparam int PtrW  = $clog2(NUM_SLOTS);
    localparam int IdxW  = $clog2(DEPTH);
    localparam int UsedW = $clog2(NUM_SLOTS + 1);

    wr_state_t       wrState;
    logic [CntW-1:0] wrCnt;
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [CntW-1:0] rdIdx;

    logic [NUM_SLOTS-1:0] slotFull;
    logic [CntW-1:0]      slotSize [NUM_SLOTS];
    logic [DATA_W-1:0]    slotData [NUM_SLOTS];

    // ---------------- write-side decode ----------------
    logic            frameEnd;
    logic            startFrame;
    logic            storeWord;
    logic            commitOk;
    logic [IdxW-1:0] wrIdx;

    assign frameEnd   = FrameError || AbortedFrame;
    // Slots fill and drain in ring order, so the slot at wrPtr is free
    // exactly when at least one slot is free.
    assign startFrame = (wrState == WR_IDLE) && WrBuff && !slotFull[wrPtr];
    // EoF outranks a same-cycle word, and an error/abort outranks a word too.
    assign storeWord  = startFrame ||
                        ((wrState == WR_FILL) && !EoF && !frameEnd && WrBuff &&
                         (wrCnt < CntW'(DEPTH)));
    assign commitOk   = (wrState == WR_FILL) && EoF && !frameEnd && !Overflow &&
                        (wrCnt > CntW'(FCS_BYTES));
    assign wrIdx      = startFrame ? '0 : wrCnt[IdxW-1:0];

    // ---------------- read-side decode ----------------
    logic            headFull;
    logic [CntW-1:0] headSize;
    logic            relHead;
    logic            stepIdx;
    logic            lastWord;

    assign headFull = slotFull[rdPtr];
    assign headSize = slotSize[rdPtr];
    assign lastWord = (rdIdx == headSize - CntW'(1));
    // Drop wins over a simultaneous ReadBuff.
    assign relHead  = headFull && (Drop || (ReadBuff && lastWord));
    assign stepIdx  = headFull && !Drop && ReadBuff && !lastWord;

    // ---------------- slots ----------------
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : gSlot
            rx_slot_mem #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .CNT_W  (CntW),
                .IDX_W  (IdxW)
            ) uSlot (
                .Clk        (Clk),
                .Rst        (Rst),
                .WrEn       (storeWord && (wrPtr == PtrW'(gi))),
                .WrIdx      (wrIdx),
                .WrData     (DataBuff),
                .Commit     (commitOk && (wrPtr == PtrW'(gi))),
                .CommitSize (wrCnt - CntW'(FCS_BYTES)),
                .RelSlot    (relHead && (rdPtr == PtrW'(gi))),
                .RdIdx      (rdIdx[IdxW-1:0]),
                .RdData     (slotData[gi]),
                .Full       (slotFull[gi]),
                .Size       (slotSize[gi])
            );
        end
    endgenerate

    // ---------------- write FSM ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wrState   <= WR_IDLE;
            wrCnt     <= '0;
            wrPtr     <= '0;
            Overflow  <= 1'b0;
            FrameLost <= 1'b0;
        end else begin
            FrameLost <= 1'b0;
            case (wrState)
                WR_IDLE: begin
                    if (WrBuff) begin
                        if (!slotFull[wrPtr]) begin
                            wrCnt   <= CntW'(1);
                            wrState <= WR_FILL;
                        end else begin
                            FrameLost <= 1'b1;
                            wrState   <= WR_SKIP;
                        end
                    end
                end
                WR_FILL: begin
                    if (EoF) begin
                        if (commitOk) begin
                            wrPtr <= wrPtr + PtrW'(1);
                        end
                        Overflow <= 1'b0;
                        wrState  <= WR_IDLE;
                    end else if (frameEnd) begin
                        Overflow <= 1'b0;
                        wrState  <= WR_IDLE;
                    end else if (WrBuff) begin
                        if (wrCnt < CntW'(DEPTH)) begin
                            wrCnt <= wrCnt + CntW'(1);
                        end else begin
                            Overflow <= 1'b1;
                        end
                    end
                end
                WR_SKIP: begin
                    if (EoF || frameEnd) begin
                        wrState <= WR_IDLE;
                    end
                end
                default: wrState <= WR_IDLE;
            endcase
        end
    end

    // ---------------- read pointers and occupancy ----------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rdPtr     <= '0;
            rdIdx     <= '0;
            SlotsUsed <= '0;
        end else begin
            if (relHead) begin
                rdIdx <= '0;
                rdPtr <= rdPtr + PtrW'(1);
            end else if (stepIdx) begin
                rdIdx <= rdIdx + CntW'(1);
            end
            // Commit and release in the same cycle cancel out.
            case ({commitOk, relHead})
                2'b10:   SlotsUsed <= SlotsUsed + UsedW'(1);
                2'b01:   SlotsUsed <= SlotsUsed - UsedW'(1);
                default: SlotsUsed <= SlotsUsed;
            endcase
        end
    end

    // ---------------- output mux ----------------
    assign RxReady       = headFull;
    assign RxDataBuffOut = headFull ? slotData[rdPtr] : '0;
    assign FrameSize     = headFull ? headSize : '0;

endmodule
